// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, blank-digit code and counter sizing for bin2bcd_seq
package bin2bcd_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble cell, adds 3 to a BCD digit that is 5 or more
module bcd_digit_adj (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with start/done handshake
// Optional leading-zero blanking when BIN2BCD_BLANK_LEADING_ZERO_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = cnt_w(BIN_W);
  state_t           r_state, w_state_n;
  logic [BIN_W-1:0] r_shreg;
  logic [W-1:0]     r_work, r_bcd, w_adj, w_work_n, w_fin;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_work, r_ovf, r_done, w_done_n, w_ovf_n, w_last, w_accept;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.i_d(r_work[4*g +: 4]), .o_d(w_adj[4*g +: 4]));
  end
  assign w_work_n = {w_adj[W-2:0], r_shreg[BIN_W-1]};
  assign w_ovf_n  = r_ovf_work | w_adj[W-1];
  assign w_last   = r_cnt == CW'(BIN_W - 1);
  assign w_accept = r_state == IDLE && start;
`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
  logic w_lead;
  always_comb begin
    w_fin  = w_work_n;
    w_lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--)
      if (w_lead && !w_ovf_n && w_work_n[4*i +: 4] == 4'd0) w_fin[4*i +: 4] = DIGIT_BLANK;
      else w_lead = 1'b0;
  end
`else
  assign w_fin = w_work_n;
`endif
  always_comb begin
    w_state_n = r_state;
    w_done_n  = 1'b0;
    if (w_accept) w_state_n = SHIFT;
    else if (r_state == SHIFT && w_last) begin
      w_state_n = IDLE;
      w_done_n  = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_work <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done  <= w_done_n;
      if (w_accept) begin
        r_shreg    <= bin;
        r_work     <= '0;
        r_cnt      <= '0;
        r_ovf_work <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_shreg    <= {r_shreg[BIN_W-2:0], 1'b0};
        r_work     <= w_work_n;
        r_cnt      <= r_cnt + 1'b1;
        r_ovf_work <= w_ovf_n;
        if (w_last) begin
          r_bcd <= w_fin;
          r_ovf <= w_ovf_n;
        end
      end
    end
  end
  assign busy = r_state == SHIFT;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of bin2bcd_seq (5-digit and 4-digit overflow instances)
module tb_bin2bcd_seq;
  logic        clock = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf, busy4, done4, ovf4;
  logic [19:0] bcd;
  logic [15:0] bcd4;
  int          n_chk = 0, n_err = 0;
  always #5 clock = ~clock;
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clock(clock), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clock(clock), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4));
`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
  localparam logic [19:0] E0 = 20'hFFFF0, E1234 = 20'hF1234, E100 = 20'hFF100,
                          E7 = 20'hFFFF7, E42 = 20'hFFF42;
`else
  localparam logic [19:0] E0 = 20'h00000, E1234 = 20'h01234, E100 = 20'h00100,
                          E7 = 20'h00007, E42 = 20'h00042;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      tick();
      lat++;
    end
  endtask
  task automatic conv(input logic [15:0] v, output int lat, output int bc);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, lat, bc);
  endtask
  initial begin
    int lat, bc, seen;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_ovf", ovf, 0);
    resetn = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    conv(16'd0, lat, bc);
    check("zero_lat", lat, 17);
    check("zero_busy_cycles", bc, 16);
    check("zero_bcd", bcd, E0);
    check("zero_ovf", ovf, 0);
    tick();
    check("done_one_cycle", done, 0);
    conv(16'd65535, lat, bc);
    check("max_lat", lat, 17);
    check("max_bcd", bcd, 20'h65535);
    check("max_ovf", ovf, 0);
    check("ovf4_bcd", bcd4, 16'h5535);
    check("ovf4_ovf", ovf4, 1);
    tick();
    conv(16'd1234, lat, bc);
    check("b1234_bcd", bcd, E1234);
    check("b1234_ovf4", ovf4, 0);
    tick();
    bin   = 16'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    bin   = 16'd999;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 16'd0;
    wait_done(5, lat, bc);
    check("ign_lat", lat, 17);
    check("ign_bcd", bcd, E100);
    bin   = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(1, lat, bc);
    check("b2b_lat", lat, 17);
    check("b2b_bcd", bcd, E7);
    tick();
    conv(16'd42, lat, bc);
    check("b42_bcd", bcd, E42);
    tick();
    conv(16'd10005, lat, bc);
    check("b10005_bcd", bcd, 20'h10005);
    tick();
    bin   = 16'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_bcd", bcd, 0);
    check("arst_ovf", ovf, 0);
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) seen++;
    end
    check("arst_no_done", seen, 0);
    check("arst_bcd_hold", bcd, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
